op_dispatch: RTL

- Sequential successor to the combinational bfloat16 operand/result mux.
- Accepts one request (mode, in1, in2) over a valid/ready handshake and registers the operands onto the selected unit's op_intf; unselected units see all-zero operands.
- Waits a per-mode, parametrised unit latency, captures result and overflow into an output register, and presents them over a second valid/ready handshake.
- Sits between the top-level command front end and the add/sub/mul/div units; supports pipelined or multi-cycle arithmetic units.

---
 rtl/data_type_pkg.sv | 14 +
 rtl/op_dispatch_if.sv | 17 +
 rtl/op_dispatch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_type_pkg.sv
// Shared bfloat16 data and mode definitions for the dispatcher and arithmetic units.
// DATA_WIDTH is {sign, exp[7:0], frac[6:0]}. Modes are 3 bits wide so that
// illegal encodings (4..7) exist and can be flagged.
package data_type_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned MODE_WIDTH = 3;

  localparam logic [MODE_WIDTH-1:0] MODE_ADD = 3'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_SUB = 3'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_MUL = 3'd2;
  localparam logic [MODE_WIDTH-1:0] MODE_DIV = 3'd3;

endpackage

// File: rtl/op_dispatch_if.sv
// op_intf: operand/result bundle between the dispatcher and one arithmetic unit.
//   op1, op2  : operands, driven by the dispatcher (bus_side / master)
//   op3       : result, driven by the unit (unit_side / slave)
//   overflow  : result overflow flag, driven by the unit
interface op_intf;
  import data_type_pkg::*;

  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [DATA_WIDTH-1:0] op3;
  logic                  overflow;

  modport bus_side  (output op1, output op2, input  op3, input  overflow);
  modport unit_side (input  op1, input  op2, output op3, output overflow);
  modport master    (output op1, output op2, input  op3, input  overflow);
  modport slave     (input  op1, input  op2, output op3, output overflow);
endinterface

// File: rtl/op_dispatch.sv
// op_dispatch: sequential bfloat16 operand dispatcher / result collector.
// Accepts one (mode, in1, in2) request on a valid/ready handshake, registers the
// operands onto the selected unit's op_intf (other units see zeros), waits the
// per-mode latency, captures op3/overflow and presents them on an output
// valid/ready handshake. A new request may be accepted in the same cycle the
// result is consumed.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   in_valid_i/in_ready_o         request handshake; mode_i, in1_i, in2_i payload
//   out_valid_o/out_ready_i       result handshake; out_o, overflow_o, err_o payload
//   add/sub/mul/div_intf          unit interfaces (bus_side)
// Optional (macro OP_DISPATCH_STICKY_OVF_EN):
//   ovf_sticky_o                  sticky overflow flag
//   ovf_clr_i                     synchronous clear of the sticky flag (set wins)
module op_dispatch
  import data_type_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 7,
  parameter int unsigned ADD_LAT    = 1,
  parameter int unsigned SUB_LAT    = 1,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned DIV_LAT    = 8,
  parameter int unsigned CNT_WIDTH  = 4,
  localparam int unsigned DataW     = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [MODE_WIDTH-1:0] mode_i,
  input  logic [DataW-1:0]      in1_i,
  input  logic [DataW-1:0]      in2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DataW-1:0]      out_o,
  output logic                  overflow_o,
  output logic                  err_o,
`ifdef OP_DISPATCH_STICKY_OVF_EN
  output logic                  ovf_sticky_o,
  input  logic                  ovf_clr_i,
`endif
  op_intf.bus_side              add_intf,
  op_intf.bus_side              sub_intf,
  op_intf.bus_side              mul_intf,
  op_intf.bus_side              div_intf
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic [DataW-1:0]      in1_q, in1_d, in2_q, in2_d;
  logic [DataW-1:0]      out_q, out_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, err_q, err_d;

  logic                  accept, capture;
  logic                  sel_add, sel_sub, sel_mul, sel_div, illegal_q;
  logic [CNT_WIDTH-1:0]  lat_init;
  logic [DataW-1:0]      res;
  logic                  res_ovf;

  assign in_ready_o  = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign capture     = (state_q == StBusy) && (cnt_q == '0);
  assign out_valid_o = (state_q == StDone);
  assign out_o       = out_q;
  assign overflow_o  = ovf_q;
  assign err_o       = err_q;

  // Unit selection comes from the latched mode, so operands only move on accept.
  assign sel_add   = (mode_q == MODE_ADD);
  assign sel_sub   = (mode_q == MODE_SUB);
  assign sel_mul   = (mode_q == MODE_MUL);
  assign sel_div   = (mode_q == MODE_DIV);
  assign illegal_q = !(sel_add || sel_sub || sel_mul || sel_div);

  assign add_intf.op1 = sel_add ? in1_q : '0;
  assign add_intf.op2 = sel_add ? in2_q : '0;
  assign sub_intf.op1 = sel_sub ? in1_q : '0;
  assign sub_intf.op2 = sel_sub ? in2_q : '0;
  assign mul_intf.op1 = sel_mul ? in1_q : '0;
  assign mul_intf.op2 = sel_mul ? in2_q : '0;
  assign div_intf.op1 = sel_div ? in1_q : '0;
  assign div_intf.op2 = sel_div ? in2_q : '0;

  // Counter preload is LAT-1 so the capture happens in cycle T+LAT.
  always_comb begin
    lat_init = '0;
    case (mode_i)
      MODE_ADD: lat_init = CNT_WIDTH'(ADD_LAT - 1);
      MODE_SUB: lat_init = CNT_WIDTH'(SUB_LAT - 1);
      MODE_MUL: lat_init = CNT_WIDTH'(MUL_LAT - 1);
      MODE_DIV: lat_init = CNT_WIDTH'(DIV_LAT - 1);
      default:  lat_init = '0;
    endcase
  end

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    unique case (mode_q)
      MODE_ADD: begin res = add_intf.op3; res_ovf = add_intf.overflow; end
      MODE_SUB: begin res = sub_intf.op3; res_ovf = sub_intf.overflow; end
      MODE_MUL: begin res = mul_intf.op3; res_ovf = mul_intf.overflow; end
      MODE_DIV: begin res = div_intf.op3; res_ovf = div_intf.overflow; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: ;
      StBusy: begin
        if (capture) begin
          out_d   = res;
          ovf_d   = res_ovf;
          err_d   = illegal_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      StDone: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Accept is only possible in IDLE or in DONE with the result consumed.
    if (accept) begin
      mode_d  = mode_i;
      in1_d   = in1_i;
      in2_d   = in2_i;
      cnt_d   = lat_init;
      state_d = StBusy;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

`ifdef OP_DISPATCH_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set has priority over clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr_i) sticky_d = 1'b0;
    if (capture && res_ovf) sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sticky_q <= 1'b0;
    else         sticky_q <= sticky_d;
  end

  assign ovf_sticky_o = sticky_q;
`endif

endmodule
